reserved_exit_request_ctrl: RTL and testbench

- Synchronous front-end for the reserved-parking exit path: holds the live per-flat reserved-slot occupancy bitmap.
- Accepts exit requests by flat number through a valid/ready handshake and validates them against the bitmap.
- On a valid exit, clears the slot, drives the exit barrier, and reports a status code to the logging/display stage downstream.
- Entry events from the reserved-entry path set occupancy bits through a separate port.

---
 rtl/reserved_exit_request_ctrl_if.sv | 28 ++
 rtl/reserved_exit_request_ctrl.sv | 156 +++++++++++++++
 tb/tb_reserved_exit_request_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reserved_exit_request_ctrl_if.sv
// Exit-path bus for reserved_exit_request_ctrl: entry events, exit handshake,
// barrier control, status response and live occupancy bitmap.
interface reserved_exit_request_ctrl_if #(
  parameter int N_SLOTS = 8,
  parameter int FLAT_W  = $clog2(N_SLOTS) + 1
);
  logic               entry_valid;
  logic [FLAT_W-1:0]  entry_flat;
  logic               exit_valid;
  logic [FLAT_W-1:0]  exit_flat;
  logic               exit_ready;
  logic               vehicle_clear;
  logic               gate_open;
  logic               resp_valid;
  logic [1:0]         resp_code;
  logic [FLAT_W-1:0]  resp_flat;
  logic [N_SLOTS-1:0] occupancy;

  modport master (
    output entry_valid, entry_flat, exit_valid, exit_flat, vehicle_clear,
    input  exit_ready, gate_open, resp_valid, resp_code, resp_flat, occupancy
  );

  modport slave (
    input  entry_valid, entry_flat, exit_valid, exit_flat, vehicle_clear,
    output exit_ready, gate_open, resp_valid, resp_code, resp_flat, occupancy
  );
endinterface

// File: rtl/reserved_exit_request_ctrl.sv
// Reserved-parking exit controller: validates exit requests against the slot bitmap,
// drives the barrier and reports a status code. Optional stats via RESERVED_EXIT_STATS_EN.
module reserved_exit_request_ctrl #(
  parameter int N_SLOTS     = 8,
  parameter int FLAT_W      = $clog2(N_SLOTS) + 1,
  parameter int GATE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  reserved_exit_request_ctrl_if.slave bus
`ifdef RESERVED_EXIT_STATS_EN
  ,
  output logic [15:0] invalid_cnt
`endif
);

  localparam int TIMER_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [1:0] CODE_EXITED  = 2'd0;
  localparam logic [1:0] CODE_EMPTY   = 2'd1;
  localparam logic [1:0] CODE_BADFLAT = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, OPEN, DONE} state_t;

  state_t             state_q, state_d;
  logic [FLAT_W-1:0]  flat_q, flat_d;
  logic [1:0]         code_q, code_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic               exit_ready_q, exit_ready_d;
  logic               gate_open_q, gate_open_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_code_q, resp_code_d;
  logic [FLAT_W-1:0]  resp_flat_q, resp_flat_d;

  logic [N_SLOTS-1:0] entry_mask;
  logic [N_SLOTS-1:0] exit_mask;

  // One-hot slot decode; flat 0 and flats above N_SLOTS decode to all-zero masks.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_decode
    assign entry_mask[gi] = bus.entry_valid && (bus.entry_flat == FLAT_W'(gi + 1));
    assign exit_mask[gi]  = (flat_q == FLAT_W'(gi + 1));
  end

  always_comb begin
    state_d      = state_q;
    flat_d       = flat_q;
    code_d       = code_q;
    timer_d      = timer_q;
    occ_d        = occ_q | entry_mask;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    resp_flat_d  = resp_flat_q;

    case (state_q)
      IDLE: begin
        if (bus.exit_valid && exit_ready_q) begin
          flat_d  = bus.exit_flat;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (exit_mask == '0) begin
          code_d  = CODE_BADFLAT;
          state_d = DONE;
        end else if ((exit_mask & occ_q) == '0) begin
          code_d  = CODE_EMPTY;
          state_d = DONE;
        end else begin
          // Clearing after the entry merge makes a same-edge entry lose.
          occ_d   = occ_d & ~exit_mask;
          timer_d = '0;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (bus.vehicle_clear) begin
          code_d  = CODE_EXITED;
          state_d = DONE;
        end else if (timer_q == TIMER_W'(GATE_CYCLES - 1)) begin
          occ_d   = occ_d | exit_mask;
          code_d  = CODE_TIMEOUT;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        resp_valid_d = 1'b1;
        resp_code_d  = code_q;
        resp_flat_d  = flat_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    exit_ready_d = (state_d == IDLE);
    gate_open_d  = (state_d == OPEN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flat_q       <= '0;
      code_q       <= '0;
      timer_q      <= '0;
      occ_q        <= '0;
      exit_ready_q <= 1'b0;
      gate_open_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      resp_flat_q  <= '0;
    end else begin
      state_q      <= state_d;
      flat_q       <= flat_d;
      code_q       <= code_d;
      timer_q      <= timer_d;
      occ_q        <= occ_d;
      exit_ready_q <= exit_ready_d;
      gate_open_q  <= gate_open_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      resp_flat_q  <= resp_flat_d;
    end
  end

  assign bus.exit_ready = exit_ready_q;
  assign bus.gate_open  = gate_open_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
  assign bus.resp_flat  = resp_flat_q;
  assign bus.occupancy  = occ_q;

`ifdef RESERVED_EXIT_STATS_EN
  logic [15:0] invalid_cnt_q, invalid_cnt_d;

  always_comb begin
    invalid_cnt_d = invalid_cnt_q;
    if (state_q == DONE && code_q != CODE_EXITED && invalid_cnt_q != 16'hFFFF) begin
      invalid_cnt_d = invalid_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      invalid_cnt_q <= '0;
    end else begin
      invalid_cnt_q <= invalid_cnt_d;
    end
  end

  assign invalid_cnt = invalid_cnt_q;
`endif

endmodule

// File: tb/tb_reserved_exit_request_ctrl.sv
// Directed bench for reserved_exit_request_ctrl: a vector table of entry+exit
// transactions plus hand sequences for same-edge conflict and reset during OPEN.
module tb_reserved_exit_request_ctrl;
  localparam int N_SLOTS     = 8;
  localparam int FLAT_W      = 4;
  localparam int GATE_CYCLES = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reserved_exit_request_ctrl_if #(.N_SLOTS(N_SLOTS), .FLAT_W(FLAT_W)) bus();
`ifdef RESERVED_EXIT_STATS_EN
  logic [15:0] invalid_cnt;
`endif

  reserved_exit_request_ctrl #(
    .N_SLOTS(N_SLOTS), .FLAT_W(FLAT_W), .GATE_CYCLES(GATE_CYCLES)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef RESERVED_EXIT_STATS_EN
    ,
    .invalid_cnt(invalid_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] ent;
    logic [3:0] ex;
    int         clr_k;
    logic [7:0] exp_pre;
    logic [1:0] exp_code;
    int         exp_lat;
    int         exp_gate;
    logic [7:0] exp_occ;
  } vec_t;

  vec_t vecs[9];

  task automatic do_entry(input logic [3:0] f);
    @(negedge clk);
    bus.entry_valid = 1'b1;
    bus.entry_flat  = f;
    @(negedge clk);
    bus.entry_valid = 1'b0;
  endtask

  // Issue one exit; vehicle_clear is driven k cycles after the accept edge.
  task automatic run_exit(input logic [3:0] f, input int clr_k,
                          output logic [1:0] code, output logic [3:0] rflat,
                          output int lat, output int gate_cyc, output logic one_cycle);
    int n;
    n = 0;
    lat = -1; gate_cyc = 0; code = 2'bxx; rflat = 4'hx; one_cycle = 1'b0;
    while (!bus.exit_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.exit_ready) return;
    bus.exit_valid = 1'b1;
    bus.exit_flat  = f;
    @(negedge clk);
    bus.exit_valid = 1'b0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      bus.vehicle_clear = (c == clr_k);
      if (bus.gate_open) gate_cyc++;
      if (bus.resp_valid) begin
        lat   = c;
        code  = bus.resp_code;
        rflat = bus.resp_flat;
      end
    end
    bus.vehicle_clear = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      one_cycle = !bus.resp_valid;
    end
  endtask

  initial begin
    logic [1:0] code;
    logic [3:0] rflat;
    int lat, gate_cyc, exp_invalid, pulses;
    logic one_cycle;

    vecs[0] = '{4'd3, 4'd3,  5, 8'h04, 2'd0,  7,  5, 8'h00};
    vecs[1] = '{4'd0, 4'd5, -1, 8'h00, 2'd1,  2,  0, 8'h00};
    vecs[2] = '{4'd0, 4'd0, -1, 8'h00, 2'd2,  2,  0, 8'h00};
    vecs[3] = '{4'd9, 4'd9, -1, 8'h00, 2'd2,  2,  0, 8'h00};
    vecs[4] = '{4'd2, 4'd2, -1, 8'h02, 2'd3, 18, 16, 8'h02};
    vecs[5] = '{4'd7, 4'd2,  1, 8'h42, 2'd0,  3,  1, 8'h40};
    vecs[6] = '{4'd8, 4'd8, 16, 8'hC0, 2'd0, 18, 16, 8'h40};
    vecs[7] = '{4'd1, 4'd1,  2, 8'h41, 2'd0,  4,  2, 8'h40};
    vecs[8] = '{4'd7, 4'd6, -1, 8'h40, 2'd1,  2,  0, 8'h40};

    rst_n = 1'b0;
    bus.entry_valid = 1'b0; bus.entry_flat = '0;
    bus.exit_valid = 1'b0;  bus.exit_flat = '0;
    bus.vehicle_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_occ",        32'(bus.occupancy),  32'h0);
    check("rst_exit_ready", 32'(bus.exit_ready), 32'h0);
    check("rst_gate",       32'(bus.gate_open),  32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp_code",  32'(bus.resp_code),  32'h0);
    check("rst_resp_flat",  32'(bus.resp_flat),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.exit_ready), 32'h1);

    exp_invalid = 0;
    for (int i = 0; i < 9; i++) begin
      do_entry(vecs[i].ent);
      check($sformatf("v%0d_occ_pre", i), 32'(bus.occupancy), 32'(vecs[i].exp_pre));
      run_exit(vecs[i].ex, vecs[i].clr_k, code, rflat, lat, gate_cyc, one_cycle);
      check($sformatf("v%0d_latency", i), 32'(lat),            32'(vecs[i].exp_lat));
      check($sformatf("v%0d_code", i),    32'(code),           32'(vecs[i].exp_code));
      check($sformatf("v%0d_flat", i),    32'(rflat),          32'(vecs[i].ex));
      check($sformatf("v%0d_gate", i),    32'(gate_cyc),       32'(vecs[i].exp_gate));
      check($sformatf("v%0d_pulse", i),   32'(one_cycle),      32'h1);
      check($sformatf("v%0d_occ", i),     32'(bus.occupancy),  32'(vecs[i].exp_occ));
      $display("vec %0d: entry=%0d exit=%0d code=%0d lat=%0d gate=%0d occ=%02h",
               i, vecs[i].ent, vecs[i].ex, code, lat, gate_cyc, bus.occupancy);
      if (vecs[i].exp_code != 2'd0) exp_invalid++;
    end
`ifdef RESERVED_EXIT_STATS_EN
    check("invalid_cnt_table", 32'(invalid_cnt), 32'(exp_invalid));
`endif

    // Entry for flat 4 lands on the same edge CHECK clears flat 4.
    do_entry(4'd4);
    check("seqA_occ_pre", 32'(bus.occupancy), 32'h48);
    bus.exit_valid = 1'b1;
    bus.exit_flat  = 4'd4;
    @(negedge clk);
    bus.exit_valid  = 1'b0;
    bus.entry_valid = 1'b1;
    bus.entry_flat  = 4'd4;
    @(negedge clk);
    bus.entry_valid = 1'b0;
    check("seqA_occ_conflict", 32'(bus.occupancy),  32'h40);
    check("seqA_gate_open",    32'(bus.gate_open),  32'h1);
    check("seqA_not_ready",    32'(bus.exit_ready), 32'h0);
    @(negedge clk);
    check("seqA_gate_still",   32'(bus.gate_open),  32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("seqA_rst_gate",  32'(bus.gate_open),  32'h0);
    check("seqA_rst_occ",   32'(bus.occupancy),  32'h0);
    check("seqA_rst_resp",  32'(bus.resp_valid), 32'h0);
    check("seqA_rst_ready", 32'(bus.exit_ready), 32'h0);
    $display("seqA: conflict and reset during OPEN applied, occ=%02h", bus.occupancy);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.gate_open) pulses++;
    end
    check("seqA_no_resp_after_rst", 32'(pulses), 32'h0);
    check("seqA_ready_again", 32'(bus.exit_ready), 32'h1);

    run_exit(4'd3, -1, code, rflat, lat, gate_cyc, one_cycle);
    check("seqB_latency", 32'(lat),   32'd2);
    check("seqB_code",    32'(code),  32'd1);
    check("seqB_flat",    32'(rflat), 32'd3);
    $display("seqB: exit=3 code=%0d lat=%0d", code, lat);
`ifdef RESERVED_EXIT_STATS_EN
    check("invalid_cnt_after_rst", 32'(invalid_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
